// File: rtl/minmax_stream_tracker.sv
// Serial min/max selector over framed valid/ready beats; reports value, beat index, count.
// Result valid one cycle after the closing beat; input stalls (in_ready=0) while a result is held.
module minmax_stream_tracker #(
  parameter int WIDTH     = 8,
  parameter int IDX_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tc,
  input  logic                 min_max,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_value,
  output logic [IDX_WIDTH-1:0] out_index,
  output logic [IDX_WIDTH:0]   out_count,
  output logic                 out_ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = '1;

  state_t               state_q, state_d;
  logic                 tc_q, max_q;
  logic [WIDTH-1:0]     best_q, best_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [IDX_WIDTH:0]   cnt_q, cnt_d;
  logic                 accept, close, force_close, improve;
  logic [IDX_WIDTH-1:0] beat_idx;
  logic signed [WIDTH:0] new_ext, best_ext;

  assign in_ready  = rst_n && (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  // In ACCUM the count of beats already taken is the index of the incoming beat.
  assign beat_idx  = cnt_q[IDX_WIDTH-1:0];

  // One extra bit lets a single signed compare cover both signed and unsigned modes.
  assign new_ext  = {tc_q & in_data[WIDTH-1], in_data};
  assign best_ext = {tc_q & best_q[WIDTH-1], best_q};
  assign improve  = max_q ? (new_ext > best_ext) : (new_ext < best_ext);

  always_comb begin
    state_d     = state_q;
    best_d      = best_q;
    idx_d       = idx_q;
    close       = 1'b0;
    force_close = 1'b0;
    cnt_d       = (state_q == IDLE) ? (IDX_WIDTH+1)'(1) : cnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          best_d  = in_data;
          idx_d   = '0;
          close   = in_last;
          state_d = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (improve) begin
            best_d = in_data;
            idx_d  = beat_idx;
          end
          force_close = !in_last && (beat_idx == LAST_IDX);
          close       = in_last || (beat_idx == LAST_IDX);
          state_d     = close ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tc_q      <= 1'b0;
      max_q     <= 1'b0;
      best_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      out_value <= '0;
      out_index <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        best_q <= best_d;
        idx_q  <= idx_d;
        cnt_q  <= cnt_d;
        if (state_q == IDLE) begin
          tc_q  <= tc;
          max_q <= min_max;
        end
      end
      // Separate result registers keep the last answer visible while the next frame accumulates.
      if (close) begin
        out_value <= best_d;
        out_index <= idx_d;
        out_count <= cnt_d;
        out_ovf   <= force_close;
      end
    end
  end

endmodule

// File: tb/tb_minmax_stream_tracker.sv
// Bench for minmax_stream_tracker: table of frames plus hand-written hold, overflow and reset sequences.
module tb_minmax_stream_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tc, min_max, in_valid, in_last, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid, out_ovf;
  logic [7:0] out_value;
  logic [3:0] out_index;
  logic [4:0] out_count;

  minmax_stream_tracker #(.WIDTH(8), .IDX_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .tc(tc), .min_max(min_max),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_index(out_index), .out_count(out_count), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] v;
    logic [3:0] i;
    logic [4:0] c;
    logic       o;
  } exp_t;

  typedef struct packed {
    logic        tc;
    logic        mm;
    int          n;
    logic [63:0] d;
    logic [7:0]  ev;
    logic [3:0]  ei;
    logic [4:0]  ec;
  } vec_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] v, input logic [3:0] i, input logic [4:0] c,
                              input logic o);
    exp_t e;
    e.v = v; e.i = i; e.c = c; e.o = o;
    return e;
  endfunction

  // Scoreboard: one result popped per handshake seen on the negedge before it completes.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_result: got value %0h, expected no result", out_value);
        end else begin
          e = sb.pop_front();
          chk("out_value", 32'(out_value), 32'(e.v));
          chk("out_index", 32'(out_index), 32'(e.i));
          chk("out_count", 32'(out_count), 32'(e.c));
          chk("out_ovf",   32'(out_ovf),   32'(e.o));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send_beat(input logic [7:0] d, input logic last, input logic t, input logic m);
    in_valid = 1'b1; in_data = d; in_last = last; tc = t; min_max = m;
    for (int g = 0; !in_ready; g++) begin
      if (g == 200) begin
        n_chk++;
        n_fail++;
        $display("FAIL beat_wait_timeout: in_ready got 0, expected 1");
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
  endtask

  task automatic send_frame(input vec_t v);
    sb.push_back(mk(v.ev, v.ei, v.ec, 1'b0));
    for (int k = 0; k < v.n; k++) send_beat(v.d[8*k +: 8], k == v.n - 1, v.tc, v.mm);
    chk("latency_valid", 32'(out_valid), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{1'b0, 1'b1, 4, 64'h02090903, 8'h09, 4'd1, 5'd4};
    vecs[1] = '{1'b1, 1'b0, 3, 64'h7F8005,   8'h80, 4'd1, 5'd3};
    vecs[2] = '{1'b0, 1'b0, 3, 64'h7F8005,   8'h05, 4'd0, 5'd3};
    vecs[3] = '{1'b0, 1'b1, 1, 64'h42,       8'h42, 4'd0, 5'd1};
    vecs[4] = '{1'b1, 1'b1, 4, 64'hFE0180FF, 8'h01, 4'd2, 5'd4};
    vecs[5] = '{1'b0, 1'b1, 4, 64'hFE0180FF, 8'hFF, 4'd0, 5'd4};
    vecs[6] = '{1'b1, 1'b0, 3, 64'h070707,   8'h07, 4'd0, 5'd3};

    rst_n = 1'b0; tc = 1'b0; min_max = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = 8'h00; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_value", 32'(out_value), 0);
    chk("rst_out_index", 32'(out_index), 0);
    chk("rst_out_count", 32'(out_count), 0);
    chk("rst_out_ovf",   32'(out_ovf),   0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 1);

    foreach (vecs[j]) send_frame(vecs[j]);

    // Full-length frame closed by in_last on index 15: no overflow.
    sb.push_back(mk(8'h91, 4'd15, 5'd16, 1'b0));
    for (int i = 0; i < 16; i++) send_beat(8'hA0 - 8'(i), i == 15, 1'b0, 1'b0);
    chk("latency_full", 32'(out_valid), 1);

    // 17 beats without last: force-close after index 15, the 17th starts a fresh frame.
    sb.push_back(mk(8'hF0, 4'd7, 5'd16, 1'b1));
    sb.push_back(mk(8'h33, 4'd1, 5'd2, 1'b0));
    for (int i = 0; i < 16; i++) send_beat((i == 7) ? 8'hF0 : 8'h20 + 8'(i), 1'b0, 1'b0, 1'b1);
    chk("latency_ovf", 32'(out_valid), 1);
    send_beat(8'h11, 1'b0, 1'b0, 1'b1);
    send_beat(8'h33, 1'b1, 1'b0, 1'b1);

    // Backpressure in HOLD, with min_max toggled after the first beat.
    repeat (3) @(negedge clk);
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    sb.push_back(mk(8'h10, 4'd1, 5'd3, 1'b0));
    send_beat(8'h30, 1'b0, 1'b0, 1'b0);
    send_beat(8'h10, 1'b0, 1'b0, 1'b1);
    send_beat(8'h20, 1'b1, 1'b0, 1'b1);
    in_valid = 1'b1; in_data = 8'h00; in_last = 1'b1; min_max = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_ready", 32'(in_ready),  0);
      chk("hold_value", 32'(out_value), 32'h10);
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("post_hs_valid", 32'(out_valid), 0);
    chk("post_hs_value", 32'(out_value), 32'h10);
    chk("post_hs_index", 32'(out_index), 1);
    chk("post_hs_count", 32'(out_count), 3);
    chk("post_hs_ready", 32'(in_ready),  1);

    // Asynchronous reset in the middle of a frame.
    send_beat(8'h55, 1'b0, 1'b0, 1'b1);
    send_beat(8'h66, 1'b0, 1'b0, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_ready", 32'(in_ready),  0);
    chk("arst_value", 32'(out_value), 0);
    chk("arst_index", 32'(out_index), 0);
    chk("arst_count", 32'(out_count), 0);
    #4 rst_n = 1'b1;
    @(negedge clk);
    chk("arst_rel_ready", 32'(in_ready), 1);
    sb.push_back(mk(8'h12, 4'd0, 5'd2, 1'b0));
    send_beat(8'h12, 1'b0, 1'b0, 1'b0);
    send_beat(8'h34, 1'b1, 1'b0, 1'b0);
    chk("latency_after_rst", 32'(out_valid), 1);

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
